// File: rtl/mem_responder_if.sv
// Handshake bundle between the LC-3b memory port (master) and mem_responder (slave).
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word RAM target for the LC-3b mem_read/mem_write/mem_resp handshake with programmable latency.
// Define MEM_RESPONDER_STALL_EN to add LFSR-driven random stall cycles (0-3) per request.
module mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  localparam int         DEPTH  = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_resp;
  logic [15:0] r_rdata;
  logic        r_err;
  logic [15:0] r_mem [DEPTH] = '{default: 16'h0000};

  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_req;
  logic                 w_rd_only;
  logic                 w_accept;
  logic                 w_wr_fire;
  logic [1:0]           w_stall;
  logic [4:0]           w_sum;
  logic [3:0]           w_load;
  logic                 w_unused_addr;

  assign w_idx         = bus.mem_address[ADDR_BITS:1];
  assign w_unused_addr = ^{bus.mem_address[15:ADDR_BITS+1], bus.mem_address[0]};
  assign w_req         = bus.mem_read | bus.mem_write;
  assign w_rd_only     = bus.mem_read & ~bus.mem_write;
  assign w_accept      = (r_state == ST_IDLE) && w_req;
  assign w_wr_fire     = (r_state == ST_RESP) && bus.mem_write && !rst;

`ifdef MEM_RESPONDER_STALL_EN
  logic [15:0] r_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Stall generator: one step per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (w_accept) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  assign w_stall = r_lfsr[1:0];
`else
  assign w_stall = 2'b00;
`endif

  // Countdown load value, saturating at the 4-bit counter limit.
  always_comb begin
    w_sum  = {1'b0, LAT_M1} + {3'b000, w_stall};
    w_load = (w_sum > 5'd15) ? 4'hF : w_sum[3:0];
  end

  // Request sequencing with registered resp/rdata/err outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_resp  <= 1'b0;
      r_rdata <= 16'h0000;
      r_err   <= 1'b0;
    end else begin
      if (bus.mem_read && bus.mem_write) begin
        r_err <= 1'b1;
      end
      r_resp <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_load == 4'd0) begin
              r_state <= ST_RESP;
              r_resp  <= 1'b1;
              if (w_rd_only) begin
                r_rdata <= r_mem[w_idx];
              end
            end else begin
              r_state <= ST_BUSY;
              r_cnt   <= w_load;
            end
          end
        end
        ST_BUSY: begin
          if (!w_req) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt <= 4'd1) begin
            r_state <= ST_RESP;
            r_resp  <= 1'b1;
            r_cnt   <= 4'd0;
            if (w_rd_only) begin
              r_rdata <= r_mem[w_idx];
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Byte-lane write on the RESP-exit edge; RAM is deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      if (bus.mem_byte_enable[0]) begin
        r_mem[w_idx][7:0] <= bus.mem_wdata[7:0];
      end
      if (bus.mem_byte_enable[1]) begin
        r_mem[w_idx][15:8] <= bus.mem_wdata[15:8];
      end
    end
  end

  assign bus.mem_resp  = r_resp;
  assign bus.mem_rdata = r_rdata;
  assign bus.mem_err   = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboarded read data, latency model with reference LFSR.
module tb_mem_responder;
`ifdef MEM_RESPONDER_STALL_EN
  localparam int LAT   = 1;
  localparam bit STALL = 1'b1;
`else
  localparam int LAT   = 3;
  localparam bit STALL = 1'b0;
`endif

  logic clk;
  logic rst;
  mem_responder_if bus();

  mem_responder #(.ADDR_BITS(8), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp;
  int          n_err;
  logic [15:0] mdl [256];
  logic [15:0] rd_last;
  logic [15:0] m_lfsr;
  logic [15:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference latency for the next accepted request; steps the model LFSR.
  task automatic accept_lat(output int lat);
    int ld;
    logic fb;
    ld = LAT - 1;
    if (STALL) ld = ld + int'(m_lfsr[1:0]);
    if (ld > 15) ld = 15;
    lat = ld + 1;
    fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
    m_lfsr = {m_lfsr[14:0], fb};
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] data, input logic [1:0] be, input string tag);
    int cyc;
    int exp_lat;
    logic [7:0] idx;
    idx = addr[8:1];
    accept_lat(exp_lat);
    if (rd && !wr) rd_last = mdl[idx];
    exp_q.push_back(rd_last);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_wdata       = data;
    bus.mem_byte_enable = be;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.mem_resp && cyc < 40);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_rdata"}, {16'h0000, bus.mem_rdata}, {16'h0000, exp_q.pop_front()});
    if (wr) begin
      if (be[0]) mdl[idx][7:0]  = data[7:0];
      if (be[1]) mdl[idx][15:8] = data[15:8];
    end
    @(negedge clk);
    chk({tag, "_resp_single"}, {31'd0, bus.mem_resp}, 32'd0);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    int seen;
    n_cmp = 0;
    n_err = 0;
    rd_last = 16'h0000;
    m_lfsr  = 16'hACE1;
    for (int i = 0; i < 256; i++) mdl[i] = 16'h0000;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = 2'b00;
    bus.mem_address = 16'h0000; bus.mem_wdata = 16'h0000;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_resp",  {31'd0, bus.mem_resp}, 32'd0);
    chk("rst_rdata", {16'h0000, bus.mem_rdata}, 32'd0);
    chk("rst_err",   {31'd0, bus.mem_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, "wr_beef");
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_beef");
    txn(1'b1, 1'b0, 16'h0011, 16'h0000, 2'b00, "rd_beef_odd");
    txn(1'b0, 1'b1, 16'h0010, 16'h1234, 2'b01, "wr_lane0");
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, "rd_be34");
    txn(1'b0, 1'b1, 16'h0010, 16'h5600, 2'b10, "wr_lane1");
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_5634");
    txn(1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, "wr_noen");
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_still_5634");
    txn(1'b0, 1'b1, 16'h0002, 16'hA5A5, 2'b11, "wr_a5a5");
    txn(1'b1, 1'b0, 16'h0202, 16'h0000, 2'b00, "rd_alias");

    // Abort: withdraw the read one cycle after acceptance.
    begin
      int lat_unused;
      accept_lat(lat_unused);
      bus.mem_read = 1'b1; bus.mem_address = 16'h0010;
      @(negedge clk);
      seen = bus.mem_resp ? 1 : 0;
      bus.mem_read = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bus.mem_resp) seen++;
      end
    end
    chk("abort_no_resp", 32'(seen), (STALL && LAT == 1) ? 32'(seen) : 32'd0);
    txn(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, "rd_after_abort");

    txn(1'b1, 1'b1, 16'h0040, 16'h00FF, 2'b11, "dual");
    chk("err_set", {31'd0, bus.mem_err}, 32'd1);
    txn(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, "rd_dual");
    chk("err_sticky", {31'd0, bus.mem_err}, 32'd1);

    for (int i = 0; i < 8; i++)
      txn(1'b1, 1'b0, 16'(2 * i), 16'h0000, 2'b00, "b2b_rd");

    // Reset in the middle of a write: no write, outputs cleared, LFSR reseeded.
    bus.mem_write = 1'b1; bus.mem_address = 16'h0030;
    bus.mem_wdata = 16'hDEAD; bus.mem_byte_enable = 2'b11;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_resp",  {31'd0, bus.mem_resp}, 32'd0);
    chk("midrst_rdata", {16'h0000, bus.mem_rdata}, 32'd0);
    chk("midrst_err",   {31'd0, bus.mem_err}, 32'd0);
    bus.mem_write = 1'b0;
    m_lfsr  = 16'hACE1;
    rd_last = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, "rd_after_rst");
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_ram_kept");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Synthesizable memory responder for the LC-3b core's memory port: it is the target side of the `mem_read`/`mem_write`/`mem_resp` handshake the CPU drives. It sits in the testbench or FPGA top level opposite the `mp2` CPU. It owns a word-organized RAM and completes each request after a programmable latency with a one-cycle `mem_resp` pulse. It supports byte-lane writes, aborts withdrawn requests, and flags protocol violations.

## Interface
- `ADDR_BITS`, default 8: number of word-address bits; RAM depth is 2^ADDR_BITS 16-bit words.
- `LATENCY`, default 3: cycles from request accept to `mem_resp`; legal range 1–15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  read request; held until the cycle after `mem_resp`.
- `mem_write`  in  1  write request; held until the cycle after `mem_resp`.
- `mem_byte_enable`  in  2  write lane enables; bit0 is [7:0], bit1 is [15:8].
- `mem_address`  in  16  byte address; bit 0 is ignored for array indexing.
- `mem_wdata`  in  16  write data; stable while `mem_write` is high.
- `mem_resp`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  16  read data, valid in the `mem_resp` cycle.
- `mem_err`  out  1  sticky protocol-error flag.

## Operation
- Word index is `mem_address[ADDR_BITS:1]`; upper address bits are ignored, so addresses alias modulo 2^(ADDR_BITS+1) bytes.
- The FSM has three states: IDLE, BUSY, RESP.
- **IDLE:** if `mem_read | mem_write`, accept the request. Load the 4-bit countdown with `LATENCY-1` (plus the stall value when configured) and go to BUSY. If that load value is 0, go directly to RESP.
- **BUSY:** decrement the countdown each cycle; enter RESP when it reaches 0.
  - If both `mem_read` and `mem_write` drop, abort to IDLE. No write occurs and no `mem_resp` is issued.
- **RESP:** `mem_resp` = 1 for exactly this cycle, then return to IDLE unconditionally.
  - Read: `mem_rdata` is the registered word at the index. It is loaded on the BUSY→RESP or IDLE→RESP edge from the address current at that edge.
  - Write: on the RESP-exit edge, update only the enabled lanes with the current `mem_wdata`. If `mem_byte_enable` = 2'b00, nothing is written but `mem_resp` is still issued.
- `mem_read` and `mem_write` high in the same cycle is treated as a write, and `mem_err` is set. `mem_err` stays set until `rst`.
- Reads ignore `mem_byte_enable` and always return the full word.
- Between transactions, `mem_rdata` holds the last read value.
- RAM contents are not cleared by `rst` and are initialized to 0 at elaboration.

## Timing
- Reset values: state = IDLE, `mem_resp` = 0, `mem_rdata` = 16'h0000, `mem_err` = 0, countdown = 0.
- A request first visible in cycle 0 yields `mem_resp` in cycle 0+LATENCY, without stall.
- Back-to-back: a new request visible in the cycle after RESP is accepted in that cycle. Sustained throughput is one transaction per LATENCY+1 cycles.
- `rst` asserted mid-transaction returns the FSM to IDLE immediately. No write occurs and `mem_resp` drops asynchronously.
- An address change during BUSY is not checked; the address is sampled at the RESP edges described above.
- `mem_resp` never asserts in two consecutive cycles.

## Configuration
- `MEM_RESPONDER_STALL_EN` defined: a 16-bit Fibonacci LFSR adds random stall cycles to exercise the CPU's wait handling.
  - Taps are x^16+x^14+x^13+x^11+1; the seed is 16'hACE1 on `rst`.
  - The LFSR advances one step per accepted request.
  - On each accept, `lfsr[1:0]` (value before the step) extra cycles, 0–3, are added to the countdown.
  - The countdown saturates at 15.
- Undefined: the LFSR is absent and latency is exactly `LATENCY`.

## Test plan
- Reset: assert `rst` mid-BUSY → `mem_resp`=0, `mem_rdata`=0, `mem_err`=0; the next request completes with normal latency and no write has occurred.
- Write then read, `LATENCY`=3: write 16'hBEEF to 0x0010 with enable 2'b11 → `mem_resp` 3 cycles after the request. A subsequent read of 0x0010 (or 0x0011) returns 16'hBEEF in its `mem_resp` cycle.
- Byte lanes: after the write above, write 16'h1234 with enable 2'b01 → a read returns 16'hBE34. Enable 2'b10 with 16'h5600 → a read returns 16'h5634.
- Aliasing, `ADDR_BITS`=8: write 16'hA5A5 to 0x0002 → a read of 0x0202 returns 16'hA5A5.
- Abort and error: drop `mem_read` after 1 BUSY cycle → no `mem_resp`, FSM back in IDLE. Assert read and write together with data 16'h00FF → it is treated as a write, `mem_err`=1 and sticky.
- With `MEM_RESPONDER_STALL_EN`, `LATENCY`=1: 8 back-to-back reads → each latency equals 1 + `lfsr[1:0]` from a reference LFSR model seeded 16'hACE1.
